// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC front end.
//   N_FFT        samples per FFT frame
//   Q_DATA       MSB index of a sample (sample width Q_DATA+1)
//   MAX_PENDING  frames that may be buffered before the reader overruns
//   state_t      frame reader FSM states
package mfcc_pkg;

  localparam int N_FFT       = 256;
  localparam int Q_DATA      = 15;
  localparam int MAX_PENDING = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/fft_frame_reader.sv
// Reader side of the triple-bank overlap frame buffer.
// Counts completed frames from the buffer, strobes N reads per frame and re-times the
// returned samples into a framed stream (sop/eop/index) for the FFT core.
// Ports:
//   clk, reset     clock (rising edge), synchronous active-high reset
//   paquet_ready   1-cycle pulse per completed frame in the buffer
//   fft_ready      FFT can take a whole frame; only looked at in IDLE
//   rd_en          read strobe to the buffer
//   buf_valid      buffer read data valid, one cycle after rd_en
//   buf_data       buffer read data, signed
//   fft_valid      output sample valid
//   fft_data       output sample, signed
//   fft_sop        first sample of a frame
//   fft_eop        sample N-1 of a frame
//   fft_idx        index of the current output sample
//   pending        frames available but not yet read
//   overrun        sticky: frame arrived while pending was already full
//   sync_err       sticky: buf_valid did not follow rd_en by exactly one cycle
module fft_frame_reader #(
  parameter int Q_DATA      = mfcc_pkg::Q_DATA,
  parameter int N           = mfcc_pkg::N_FFT,
  parameter int MAX_PENDING = mfcc_pkg::MAX_PENDING
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     paquet_ready,
  input  logic                     fft_ready,
  output logic                     rd_en,
  input  logic                     buf_valid,
  input  logic [Q_DATA:0]          buf_data,
  output logic                     fft_valid,
  output logic [Q_DATA:0]          fft_data,
  output logic                     fft_sop,
  output logic                     fft_eop,
  output logic [$clog2(N)-1:0]     fft_idx,
  output logic [1:0]               pending,
  output logic                     overrun,
  output logic                     sync_err
);

  import mfcc_pkg::*;

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [1:0] PEND_FULL = 2'(MAX_PENDING);

  state_t           state;
  logic [IDX_W-1:0] rd_cnt;
  logic             frame_start;

  // Frame read begins on the clock edge that leaves IDLE; pending drops on that same edge.
  assign frame_start = (state == IDLE) && (pending != 2'd0) && fft_ready;

  // FSM, read strobe and pending counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_en   <= 1'b0;
      pending <= 2'd0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state  <= READ;
            rd_en  <= 1'b1;
            rd_cnt <= '0;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_IDX) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end
        end
        // Last sample comes back from the buffer during this cycle.
        DRAIN: state <= IDLE;
        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
        end
      endcase

      if (paquet_ready && !frame_start) begin
        if (pending == PEND_FULL) begin
          overrun <= 1'b1;
        end else begin
          pending <= pending + 2'd1;
        end
      end else if (frame_start && !paquet_ready) begin
        pending <= pending - 2'd1;
      end
    end
  end

  logic             exp_valid;
  logic [IDX_W-1:0] acc_cnt;

  // Registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_valid <= 1'b0;
      acc_cnt   <= '0;
      fft_valid <= 1'b0;
      fft_data  <= '0;
      fft_sop   <= 1'b0;
      fft_eop   <= 1'b0;
      fft_idx   <= '0;
      sync_err  <= 1'b0;
    end else begin
      exp_valid <= rd_en;
      if (buf_valid != exp_valid) begin
        sync_err <= 1'b1;
      end

      fft_valid <= buf_valid;
      fft_sop   <= buf_valid && (acc_cnt == '0);
      fft_eop   <= buf_valid && (acc_cnt == LAST_IDX);
      if (buf_valid) begin
        fft_data <= buf_data;
        fft_idx  <= acc_cnt;
      end

      // Realign the index at each frame so a dropped sample cannot skew later frames.
      if (frame_start) begin
        acc_cnt <= '0;
      end else if (buf_valid) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_reader.sv
module tb_fft_frame_reader;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               paquet_ready = 1'b0;
  logic               fft_ready = 1'b0;
  logic               rd_en;
  logic               buf_valid;
  logic signed [15:0] buf_data;
  logic               fft_valid;
  logic signed [15:0] fft_data;
  logic               fft_sop;
  logic               fft_eop;
  logic [7:0]         fft_idx;
  logic [1:0]         pending;
  logic               overrun;
  logic               sync_err;

  fft_frame_reader dut (
    .clk          (clk),
    .reset        (reset),
    .paquet_ready (paquet_ready),
    .fft_ready    (fft_ready),
    .rd_en        (rd_en),
    .buf_valid    (buf_valid),
    .buf_data     (buf_data),
    .fft_valid    (fft_valid),
    .fft_data     (fft_data),
    .fft_sop      (fft_sop),
    .fft_eop      (fft_eop),
    .fft_idx      (fft_idx),
    .pending      (pending),
    .overrun      (overrun),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int samples = 0;
  int sops = 0;
  int eops = 0;
  int drop_at = -1;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  idx;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Buffer model: ramp 0..N-1 per frame, one-cycle read latency, optional dropped sample.
  logic rd_prev;
  int   frame_pos;
  int   k;
  wire  mdl_start = rd_en && !rd_prev;
  wire [31:0] pos = mdl_start ? 32'd0 : 32'(frame_pos);
  wire [31:0] kk  = mdl_start ? 32'd0 : 32'(k);

  always @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      rd_prev   <= 1'b0;
      frame_pos <= 0;
      k         <= 0;
      sb.delete();
    end else begin
      rd_prev <= rd_en;
      if (rd_en) begin
        frame_pos <= int'(pos) + 1;
        if (int'(pos) == drop_at) begin
          buf_valid <= 1'b0;
          k         <= int'(kk);
        end else begin
          buf_valid <= 1'b1;
          buf_data  <= 16'(pos);
          sb.push_back('{data: 16'(pos), idx: 8'(kk), sop: (kk == 0), eop: (kk == 255)});
          k         <= int'(kk) + 1;
        end
      end else begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Monitor: pop the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && fft_valid) begin
      samples++;
      if (fft_sop) sops++;
      if (fft_eop) eops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got sample idx %0d expected none at %0t", fft_idx, $time);
      end else begin
        e = sb.pop_front();
        check("fft_data", 32'(fft_data), 32'(e.data));
        check("fft_idx", 32'(fft_idx), 32'(e.idx));
        check("fft_sop", 32'(fft_sop), 32'(e.sop));
        check("fft_eop", 32'(fft_eop), 32'(e.eop));
      end
    end
  end

  task automatic pulse();
    @(posedge clk); #1 paquet_ready = 1'b1;
    @(posedge clk); #1 paquet_ready = 1'b0;
  endtask

  // Caller must be at a negedge; returns at the negedge after the last strobe.
  task automatic read_frame(output int gap, output int n);
    gap = 0;
    n   = 0;
    while (!rd_en && gap < 50) begin gap++; @(negedge clk); end
    while (rd_en && n < 600) begin n++; @(negedge clk); end
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_en"}, 32'(rd_en), 0);
    check({tag, ".fft_valid"}, 32'(fft_valid), 0);
    check({tag, ".fft_data"}, 32'(fft_data), 0);
    check({tag, ".fft_sop"}, 32'(fft_sop), 0);
    check({tag, ".fft_eop"}, 32'(fft_eop), 0);
    check({tag, ".fft_idx"}, 32'(fft_idx), 0);
    check({tag, ".pending"}, 32'(pending), 0);
    check({tag, ".overrun"}, 32'(overrun), 0);
    check({tag, ".sync_err"}, 32'(sync_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, n, s0, e0, sp0;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Single frame
    fft_ready = 1'b1;
    s0 = samples; e0 = eops; sp0 = sops;
    pulse();
    check("t1.pending_after_pulse", 32'(pending), 1);
    @(negedge clk);
    read_frame(gap, n);
    check("t1.rd_start_gap", 32'(gap), 1);
    check("t1.rd_count", 32'(n), 256);
    check("t1.pending_end", 32'(pending), 0);
    wait_cycles(5);
    check("t1.samples", 32'(samples - s0), 256);
    check("t1.sop_count", 32'(sops - sp0), 1);
    check("t1.eop_count", 32'(eops - e0), 1);
    check("t1.sync_err", 32'(sync_err), 0);

    // Overrun with FFT not ready
    fft_ready = 1'b0;
    pulse();
    pulse();
    check("t2.pending_2", 32'(pending), 2);
    check("t2.overrun_0", 32'(overrun), 0);
    pulse();
    check("t2.overrun_1", 32'(overrun), 1);
    check("t2.pending_hold", 32'(pending), 2);
    fft_ready = 1'b1;
    s0 = samples; e0 = eops;
    @(negedge clk);
    read_frame(gap, n);
    check("t2.rd_count_a", 32'(n), 256);
    read_frame(gap, n);
    check("t2.gap_ok", 32'(gap >= 1 && gap <= 2), 1);
    check("t2.rd_count_b", 32'(n), 256);
    check("t2.pending_end", 32'(pending), 0);
    check("t2.overrun_sticky", 32'(overrun), 1);
    wait_cycles(5);
    check("t2.samples", 32'(samples - s0), 512);
    check("t2.eop_count", 32'(eops - e0), 2);

    // Pulse coincident with frame start
    fft_ready = 1'b0;
    pulse();
    check("t3.pending_1", 32'(pending), 1);
    fft_ready = 1'b1;
    paquet_ready = 1'b1;
    @(posedge clk); #1 paquet_ready = 1'b0;
    check("t3.rd_en_started", 32'(rd_en), 1);
    check("t3.pending_unchanged", 32'(pending), 1);
    s0 = samples; e0 = eops;
    @(negedge clk);
    read_frame(gap, n);
    check("t3.rd_count_a", 32'(n), 256);
    read_frame(gap, n);
    check("t3.gap_ok", 32'(gap >= 1 && gap <= 2), 1);
    check("t3.rd_count_b", 32'(n), 256);
    check("t3.pending_end", 32'(pending), 0);
    wait_cycles(5);
    check("t3.samples", 32'(samples - s0), 512);
    check("t3.eop_count", 32'(eops - e0), 2);
    check("t3.sync_err", 32'(sync_err), 0);

    // Dropped sample at position 100
    drop_at = 100;
    s0 = samples; e0 = eops;
    pulse();
    @(negedge clk);
    read_frame(gap, n);
    check("t4.rd_count", 32'(n), 256);
    wait_cycles(5);
    drop_at = -1;
    check("t4.sync_err", 32'(sync_err), 1);
    check("t4.samples", 32'(samples - s0), 255);
    check("t4.eop_count", 32'(eops - e0), 0);
    wait_cycles(10);
    check("t4.sync_err_sticky", 32'(sync_err), 1);

    // Clear sticky flags
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("t5.overrun_cleared", 32'(overrun), 0);
    check("t5.sync_err_cleared", 32'(sync_err), 0);

    // Reset mid-frame at output index 50
    e0 = eops;
    pulse();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fft_valid && fft_idx == 8'd50) begin
        found = 1'b1;
        break;
      end
    end
    check("t5.reached_idx50", 32'(found), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("t5.abort");
    @(posedge clk); #1 reset = 1'b0;
    wait_cycles(20);
    check("t5.no_eop", 32'(eops - e0), 0);
    check("t5.rd_en_idle", 32'(rd_en), 0);
    check("t5.pending_idle", 32'(pending), 0);

    // Recovery frame
    s0 = samples; e0 = eops;
    pulse();
    @(negedge clk);
    read_frame(gap, n);
    check("t6.rd_count", 32'(n), 256);
    wait_cycles(5);
    check("t6.samples", 32'(samples - s0), 256);
    check("t6.eop_count", 32'(eops - e0), 1);
    check("t6.sync_err", 32'(sync_err), 0);
    check("t6.sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
